regfile_dump_reader: RTL and testbench

- Sequential reader for the LC-3 8x16 register file.
- On a start pulse it drives a source-register select, captures the selected register's combinational read data, and presents each word to a downstream consumer (hex display driver, debug UART) over a valid/ready handshake.
- Sits beside the datapath. While Busy is high, the top level muxes SR_sel onto the register file's SR1 select.

---
 rtl/regfile_dump_reader.sv | 131 +++++++++++++
 tb/tb_regfile_dump_reader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Sequential reader for the LC-3 8x16 register file: walks First..Last (wrapping
// past the top register) and hands each word to a consumer over valid/ready.
module regfile_dump_reader #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  input  logic [IDX_W-1:0]  First,
  input  logic [IDX_W-1:0]  Last,
  input  logic [DATA_W-1:0] SR_data,
  output logic [IDX_W-1:0]  SR_sel,
  output logic              Busy,
  output logic [DATA_W-1:0] Data_out,
  output logic [IDX_W-1:0]  Index_out,
  output logic              Valid,
  input  logic              Ready,
  output logic              Done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_r;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] last_r;
  logic [IDX_W-1:0] idx_next_s;
  logic             start_ok_s;

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return (int'(idx) < NUM_REGS);
  endfunction

  function automatic logic [IDX_W-1:0] idx_advance(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] nxt;
    if (int'(idx) == NUM_REGS - 1) begin
      nxt = '0;
    end else begin
      nxt = idx + IDX_W'(1);
    end
    return nxt;
  endfunction

  // Start qualification and successor index for the walk.
  always_comb begin
    start_ok_s = Start && idx_in_range(First) && idx_in_range(Last);
    idx_next_s = idx_advance(idx_r);
  end

  // Dump sequencer; every output is a register written here.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r   <= ST_IDLE;
      idx_r     <= '0;
      last_r    <= '0;
      SR_sel    <= '0;
      Data_out  <= '0;
      Index_out <= '0;
      Valid     <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          Done <= 1'b0;
          if (start_ok_s) begin
            last_r  <= Last;
            idx_r   <= First;
            SR_sel  <= First;
            Busy    <= 1'b1;
            state_r <= ST_READ;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (Abort) begin
            Valid   <= 1'b0;
            Busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            // SR_data has been settled on SR_sel for the whole cycle.
            Data_out  <= SR_data;
            Index_out <= idx_r;
            Valid     <= 1'b1;
            state_r   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (Abort) begin
            Valid   <= 1'b0;
            Busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else if (Ready) begin
            Valid <= 1'b0;
            if (idx_r == last_r) begin
              Busy    <= 1'b0;
              Done    <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              idx_r   <= idx_next_s;
              SR_sel  <= idx_next_s;
              state_r <= ST_READ;
            end
          end else begin
            state_r <= ST_HOLD;
          end
        end
        ST_DONE: begin
          Done    <= 1'b0;
          Busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          Valid   <= 1'b0;
          Busy    <= 1'b0;
          Done    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: a register-file model feeds SR_data,
// expected words are queued per dump and popped by an independent monitor.
module tb_regfile_dump_reader;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int IDX_W    = 3;

  typedef struct {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              Clk, Reset, Start, Abort, Ready;
  logic              Busy, Valid, Done;
  logic [IDX_W-1:0]  First, Last, SR_sel, Index_out;
  logic [DATA_W-1:0] SR_data, Data_out;
  logic [DATA_W-1:0] regs [NUM_REGS];

  exp_t exp_q[$];
  int   xfer_cyc[$];
  exp_t mon_e;
  int   checks = 0, errors = 0, cyc = 0, done_cnt = 0, n_done = 0, start_cyc = 0;
  int   stall_left = 0;
  bit   stall_on = 1'b0, rand_ready = 1'b0;
  logic [IDX_W-1:0]  stall_idx = '0;
  logic [DATA_W-1:0] stall_exp = '0;

  assign SR_data = regs[SR_sel];

  regfile_dump_reader #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .First(First), .Last(Last),
    .SR_data(SR_data), .SR_sel(SR_sel), .Busy(Busy), .Data_out(Data_out),
    .Index_out(Index_out), .Valid(Valid), .Ready(Ready), .Done(Done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted transfer is matched against the head of the queue.
  always @(negedge Clk) begin
    if (!Reset && Valid && Ready && !Abort) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got index %0d data %0h, expected no transfer", Index_out, Data_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("xfer_index", 32'(Index_out), 32'(mon_e.idx));
        chk("xfer_data", 32'(Data_out), 32'(mon_e.data));
        xfer_cyc.push_back(cyc + 1);
      end
    end
    if (Done) done_cnt++;
  end

  // Consumer: Ready is 1, random, or held low for a scripted stall on one word.
  initial begin
    Ready = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      if (stall_left > 0 && (stall_on || (Valid && Index_out == stall_idx))) begin
        if (stall_on) begin
          chk("stall_valid", 32'(Valid), 32'd1);
          chk("stall_index", 32'(Index_out), 32'(stall_idx));
        end
        chk("stall_data", 32'(Data_out), 32'(stall_exp));
        stall_on = 1'b1;
        Ready = 1'b0;
        stall_left--;
      end else begin
        stall_on = 1'b0;
        Ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  task automatic preload();
    for (int i = 0; i < NUM_REGS; i++) regs[i] = DATA_W'(16'h1000 + i);
  endtask

  // Called just after a rising edge; queues the expected words in walk order.
  task automatic start_dump(input logic [IDX_W-1:0] f, input logic [IDX_W-1:0] l);
    int   i;
    exp_t e;
    i = int'(f);
    for (int k = 0; k < NUM_REGS; k++) begin
      e.idx  = IDX_W'(i);
      e.data = regs[i];
      exp_q.push_back(e);
      if (i == int'(l)) break;
      i = (i + 1) % NUM_REGS;
    end
    Start = 1'b1;
    First = f;
    Last  = l;
    start_cyc = cyc + 1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    chk("start_accepted", 32'(Busy), 32'd1);
  endtask

  task automatic wait_done(output int done_at);
    bit seen;
    seen = 1'b0;
    done_at = -1;
    for (int k = 0; k < 400; k++) begin
      if (Done) begin
        seen = 1'b1;
        done_at = cyc;
        break;
      end
      @(posedge Clk);
      #1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) n_done++;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge Clk);
    #1;
    chk("done_one_cycle", 32'(Done), 32'd0);
    chk("busy_after_done", 32'(Busy), 32'd0);
  endtask

  task automatic wait_hold(input logic [IDX_W-1:0] idx);
    for (int k = 0; k < 200; k++) begin
      if (Valid && Index_out == idx) break;
      @(posedge Clk);
      #1;
    end
    chk("hold_reached", 32'(Index_out), 32'(idx));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sr_sel"}, 32'(SR_sel), 32'd0);
    chk({tag, "_data"}, 32'(Data_out), 32'd0);
    chk({tag, "_index"}, 32'(Index_out), 32'd0);
    chk({tag, "_valid"}, 32'(Valid), 32'd0);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_done"}, 32'(Done), 32'd0);
  endtask

  initial begin
    int done_at;
    int d0;
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; First = '0; Last = '0;
    preload();
    repeat (3) @(posedge Clk);
    #1;
    chk_all_zero("reset");
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Full walk with Ready held high: timing of Valid, transfers and Done.
    xfer_cyc.delete();
    start_dump(3'd0, 3'd7);
    chk("valid_low_edge1", 32'(Valid), 32'd0);
    @(posedge Clk);
    #1;
    chk("valid_edge2", 32'(Valid), 32'd1);
    chk("first_index", 32'(Index_out), 32'd0);
    wait_done(done_at);
    chk("done_latency", 32'(done_at - start_cyc), 32'd16);
    chk("xfer_count", 32'(xfer_cyc.size()), 32'd8);
    for (int k = 0; k < 8 && k < xfer_cyc.size(); k++)
      chk("xfer_spacing", 32'(xfer_cyc[k] - start_cyc), 32'(2 + 2 * k));

    // Wrap-around and single-register dumps.
    start_dump(3'd6, 3'd1);
    wait_done(done_at);
    start_dump(3'd3, 3'd3);
    wait_done(done_at);

    // Five-cycle backpressure on R2.
    stall_idx = 3'd2; stall_exp = 16'h1002; stall_left = 5;
    start_dump(3'd0, 3'd7);
    wait_done(done_at);
    chk("stall_consumed", 32'(stall_left), 32'd0);

    // Register write while R4 is held; a re-read sees the new value.
    stall_idx = 3'd4; stall_exp = 16'h1004; stall_left = 3;
    start_dump(3'd0, 3'd7);
    wait_hold(3'd4);
    regs[4] = 16'hBEEF;
    wait_done(done_at);
    start_dump(3'd4, 3'd4);
    wait_done(done_at);
    preload();

    // Abort together with Ready while R5 is held.
    start_dump(3'd0, 3'd7);
    wait_hold(3'd5);
    d0 = done_cnt;
    Abort = 1'b1;
    @(posedge Clk);
    #1;
    Abort = 1'b0;
    chk("abort_valid", 32'(Valid), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_data_held", 32'(Data_out), 32'h1005);
    exp_q.delete();
    start_dump(3'd3, 3'd3);
    wait_done(done_at);
    chk("abort_no_done_pulse", 32'(done_cnt - d0), 32'd1);

    // Reset while in READ, with Start asserted during reset.
    start_dump(3'd0, 3'd7);
    Reset = 1'b1;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    chk_all_zero("midreset");
    Reset = 1'b0;
    Start = 1'b0;
    exp_q.delete();
    @(posedge Clk);
    #1;
    chk("reset_start_ignored", 32'(Busy), 32'd0);
    start_dump(3'd0, 3'd7);
    wait_done(done_at);

    // Randomized contents, ranges and consumer backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] = DATA_W'($urandom);
      start_dump(IDX_W'($urandom_range(0, NUM_REGS - 1)), IDX_W'($urandom_range(0, NUM_REGS - 1)));
      wait_done(done_at);
    end
    rand_ready = 1'b0;

    chk("done_pulse_count", 32'(done_cnt), 32'(n_done));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
